hw_sw_msg_receiver: RTL and testbench
=====================================

Name: hw_sw_msg_receiver

Overview:
Downstream of the CPU/hardware two-bit handshake. Uses the same to_hw_sig/to_sw_sig protocol, but also captures a data word on each handshake. Assembles one header word plus 0..MAX_WORDS payload words into a complete message. Presents the message to game logic through a valid/ready interface.

Parameters:
DATA_W, 16, width of to_hw_port and of each payload word (min 8)
MAX_WORDS, 4, maximum payload words per message (1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
to_hw_sig  in  2  CPU handshake: 0 idle, 2 word valid, 1 word done
to_hw_port  in  DATA_W  CPU data word, stable while to_hw_sig==2
to_sw_sig  out  2  handshake back to CPU: 2 = word latched, else 0
msg_valid  out  1  complete message held for game logic
msg_ready  in  1  game logic accepts message
msg_type  out  4  header bits [DATA_W-1:DATA_W-4]
msg_len  out  4  payload word count, header bits [3:0]
msg_payload  out  MAX_WORDS*DATA_W  word i at [i*DATA_W +: DATA_W]; unused words are 0
len_err  out  1  one-cycle pulse: header length > MAX_WORDS
busy  out  1  high outside IDLE, or while a message is partially assembled

Behaviour:
- Same clock domain as the CPU PIO. Inputs are sampled directly; there is no synchronizer.
- Reset (reset_n low, async) clears every register immediately:
  - state=IDLE, word counter=0, header flag=expect-header;
  - to_sw_sig=0, msg_valid=0, msg_type=0, msg_len=0, msg_payload=0, len_err=0, busy=0.
- FSM states: IDLE, ACK, RELEASE, DELIVER. to_sw_sig is decoded from state: 2 in ACK, 0 in all other states.
- IDLE: on an edge with to_hw_sig==2, latch to_hw_port and go to ACK. Every other to_hw_sig value holds IDLE.
- Latching, expecting header:
  - store type and length;
  - if length > MAX_WORDS: pulse len_err, discard the message, keep expecting a header;
  - otherwise set remaining = length.
- Latching, payload: write the word into slot (length - remaining), then decrement remaining.
- ACK: wait for to_hw_sig==1, then go to RELEASE. to_hw_sig==2 or 0 holds ACK; it never re-latches.
- RELEASE: wait for to_hw_sig==0.
  - If the message is now complete (remaining==0 after a valid header, including length 0), go to DELIVER.
  - Otherwise go to IDLE.
- DELIVER: msg_valid=1, and msg_* outputs are stable. On msg_valid & msg_ready, go to IDLE on the next edge. This clears msg_valid, sets expect-header and zeroes the payload registers.
- Backpressure: while in DELIVER, to_hw_sig==2 is ignored and to_sw_sig stays 0. The CPU therefore stalls until the message is consumed.
- Latency:
  - to_sw_sig rises 1 cycle after to_hw_sig==2 is sampled in IDLE, and falls 1 cycle after to_hw_sig==1 is sampled.
  - msg_valid rises 1 cycle after to_hw_sig==0 is sampled in RELEASE for the final word.
- Simultaneous events: msg_ready held high before DELIVER completes delivery in exactly 1 cycle. msg_valid is never asserted twice for one message.
- Reset mid-message: the partial message is dropped. The CPU must restart from the header.
- Counter width is 4 bits. remaining never wraps below 0 because the header check prevents oversize lengths.

Test Plan:
- Header 0x3002, then payload 0x00AA and 0x00BB, each with full 2→1→0 handshake, msg_ready=1 → one msg_valid pulse; msg_type=3, msg_len=2, payload words [0x00AA, 0x00BB, 0, 0]; to_sw_sig=2 exactly 3 times.
- Header 0x5000 (length 0) → msg_valid 1 cycle after to_hw_sig returns to 0; msg_type=5, msg_len=0, msg_payload=0.
- Header 0x1007 with MAX_WORDS=4 → len_err pulses once; no msg_valid; the next word 0x2001 is accepted as a header.
- msg_ready=0 for 20 cycles after a complete message, with the CPU already driving to_hw_sig=2 → to_sw_sig stays 0 and msg_* outputs stay stable. Raising msg_ready → delivery, then IDLE, then the pending word is acknowledged.
- to_hw_sig held at 2 for 10 cycles in ACK → exactly one word latched and to_sw_sig held at 2; on to_hw_sig=1, to_sw_sig drops the next cycle.
- reset_n pulsed low during the second payload word of a 3-word message → all outputs 0 immediately. A following complete message 0x4001/0x0055 is delivered correctly.

Source files
------------

// File: rtl/hw_sw_msg_receiver.sv
// Receives header + payload words over the to_hw_sig/to_sw_sig PIO handshake
// and hands each complete message to game logic on a valid/ready interface.
module hw_sw_msg_receiver #(
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    to_hw_sig,
  input  logic [DATA_W-1:0]             to_hw_port,
  output logic [1:0]                    to_sw_sig,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [3:0]                    msg_type,
  output logic [3:0]                    msg_len,
  output logic [MAX_WORDS*DATA_W-1:0]   msg_payload,
  output logic                          len_err,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  // Handshakes:
  //   CPU side  - CPU drives to_hw_sig=2 with a stable word, we answer
  //               to_sw_sig=2 once it is latched, CPU moves to 1 then 0.
  //   Game side - msg_valid holds the message until msg_ready is seen high
  //               on a clock edge; that edge completes the transfer.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_RELEASE = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

  state_t                        state_q, state_d;
  logic [3:0]                    remaining_q;
  logic                          expect_hdr_q;
  logic [3:0]                    msg_type_q;
  logic [3:0]                    msg_len_q;
  logic [MAX_WORDS*DATA_W-1:0]   payload_q;
  logic                          len_err_q;

  logic                          latch_en;
  logic                          deliver_done;
  logic                          msg_complete;
  logic [3:0]                    hdr_len;
  logic [3:0]                    hdr_type;
  logic                          hdr_oversize;
  logic [3:0]                    slot;

  assign hdr_len      = to_hw_port[3:0];
  assign hdr_type     = to_hw_port[DATA_W-1 -: 4];
  assign hdr_oversize = (hdr_len > MAX_LEN);
  assign slot         = msg_len_q - remaining_q;
  assign msg_complete = !expect_hdr_q && (remaining_q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    deliver_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (to_hw_sig == 2'd2) begin
          latch_en = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (to_hw_sig == 2'd1) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (to_hw_sig == 2'd0) state_d = msg_complete ? S_DELIVER : S_IDLE;
      end
      S_DELIVER: begin
        // CPU words are ignored here, which stalls the CPU until consumed.
        if (msg_ready) begin
          deliver_done = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q  <= 4'd0;
      expect_hdr_q <= 1'b1;
      msg_type_q   <= 4'd0;
      msg_len_q    <= 4'd0;
      payload_q    <= '0;
      len_err_q    <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      if (deliver_done) begin
        expect_hdr_q <= 1'b1;
        payload_q    <= '0;
      end else if (latch_en) begin
        if (expect_hdr_q) begin
          msg_type_q <= hdr_type;
          msg_len_q  <= hdr_len;
          if (hdr_oversize) begin
            // Oversize header is dropped; the next word is again a header.
            len_err_q <= 1'b1;
          end else begin
            remaining_q  <= hdr_len;
            expect_hdr_q <= 1'b0;
          end
        end else begin
          for (int i = 0; i < MAX_WORDS; i++) begin
            if (slot == 4'(i)) payload_q[i*DATA_W +: DATA_W] <= to_hw_port;
          end
          remaining_q <= remaining_q - 4'd1;
        end
      end
    end
  end

  assign to_sw_sig   = (state_q == S_ACK) ? 2'd2 : 2'd0;
  assign msg_valid   = (state_q == S_DELIVER);
  assign msg_type    = msg_type_q;
  assign msg_len     = msg_len_q;
  assign msg_payload = payload_q;
  assign len_err     = len_err_q;
  assign busy        = (state_q != S_IDLE) || !expect_hdr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hw_sw_msg_receiver.sv
// Bench for hw_sw_msg_receiver: drives CPU word handshakes and checks
// delivered messages against an expected-message queue.
module tb_hw_sw_msg_receiver;

  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 4;
  localparam int PW        = MAX_WORDS*DATA_W;
  localparam int W         = 8 + PW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        to_hw_sig;
  logic [DATA_W-1:0] to_hw_port;
  logic [1:0]        to_sw_sig;
  logic              msg_valid;
  logic              msg_ready;
  logic [3:0]        msg_type;
  logic [3:0]        msg_len;
  logic [PW-1:0]     msg_payload;
  logic              len_err;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int lerr_cnt = 0;
  logic [1:0] prev_sw = 2'd0;
  logic [W-1:0] exp_q[$];

  hw_sw_msg_receiver #(.DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .to_hw_sig(to_hw_sig), .to_hw_port(to_hw_port),
    .to_sw_sig(to_sw_sig), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_type(msg_type), .msg_len(msg_len), .msg_payload(msg_payload),
    .len_err(len_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] t, input logic [3:0] l,
      input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
    return {t, l, w3, w2, w1, w0};
  endfunction

  // Monitor samples just after the falling edge: inputs and outputs there are
  // what the DUT sees on the following rising edge.
  always begin
    @(negedge clk);
    #1;
    if (to_sw_sig == 2'd2 && prev_sw != 2'd2) ack_cnt++;
    prev_sw = to_sw_sig;
    if (len_err) lerr_cnt++;
    if (reset_n && msg_valid && msg_ready) begin
      if (exp_q.size() == 0) check("unexpected_msg", 1, 0);
      else check("msg", {msg_type, msg_len, msg_payload}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_sw(input logic [1:0] val, input string tag);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (to_sw_sig == val) ok = 1;
    end
    if (!ok) check(tag, 0, 1);
  endtask

  task automatic finish_word();
    wait_sw(2'd2, "ack_timeout");
    to_hw_sig = 2'd1;
    wait_sw(2'd0, "release_timeout");
    to_hw_sig = 2'd0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    @(negedge clk);
    to_hw_port = w;
    to_hw_sig  = 2'd2;
    finish_word();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] held;
    reset_n    = 1'b0;
    to_hw_sig  = 2'd0;
    to_hw_port = '0;
    msg_ready  = 1'b1;
    @(negedge clk);
    check("reset_outputs", {to_sw_sig, msg_valid, msg_type, msg_len, msg_payload, len_err, busy}, 0);
    check("reset_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Two-word message
    ack_cnt = 0;
    exp_q.push_back(pack(4'd3, 4'd2, 16'h00AA, 16'h00BB, 16'h0, 16'h0));
    send_word(16'h3002);
    repeat (2) @(negedge clk);
    check("busy_partial", busy, 1);
    send_word(16'h00AA);
    send_word(16'h00BB);
    repeat (4) @(negedge clk);
    check("two_word_acks", ack_cnt, 3);
    check("two_word_delivered", exp_q.size(), 0);
    check("busy_after", busy, 0);

    // Zero-length message: valid one cycle after to_hw_sig returns to 0
    exp_q.push_back(pack(4'd5, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    send_word(16'h5000);
    @(negedge clk);
    check("len0_latency", msg_valid, 1);
    repeat (3) @(negedge clk);
    check("len0_delivered", exp_q.size(), 0);

    // Oversize header is dropped, next word is a header
    lerr_cnt = 0;
    send_word(16'h1007);
    repeat (3) @(negedge clk);
    check("len_err_count", lerr_cnt, 1);
    check("oversize_busy", busy, 0);
    exp_q.push_back(pack(4'd2, 4'd1, 16'h0011, 16'h0, 16'h0, 16'h0));
    send_word(16'h2001);
    send_word(16'h0011);
    repeat (3) @(negedge clk);
    check("after_err_delivered", exp_q.size(), 0);
    check("len_err_once", lerr_cnt, 1);

    // Backpressure with the CPU already presenting a word
    msg_ready = 1'b0;
    exp_q.push_back(pack(4'd6, 4'd1, 16'h1234, 16'h0, 16'h0, 16'h0));
    send_word(16'h6001);
    send_word(16'h1234);
    @(negedge clk);
    held = pack(4'd6, 4'd1, 16'h1234, 16'h0, 16'h0, 16'h0);
    to_hw_port = 16'h7000;
    to_hw_sig  = 2'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {to_sw_sig, msg_valid, msg_type, msg_len, msg_payload}, {2'd0, 1'b1, held});
    end
    exp_q.push_back(pack(4'd7, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0));
    msg_ready = 1'b1;
    finish_word();
    repeat (4) @(negedge clk);
    check("bp_delivered", exp_q.size(), 0);

    // to_hw_sig held at 2 in ACK for 10 cycles
    ack_cnt = 0;
    exp_q.push_back(pack(4'd8, 4'd1, 16'h00CC, 16'h0, 16'h0, 16'h0));
    @(negedge clk);
    to_hw_port = 16'h8001;
    to_hw_sig  = 2'd2;
    wait_sw(2'd2, "hold_ack_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_ack", to_sw_sig, 2);
    end
    to_hw_sig = 2'd1;
    @(negedge clk);
    check("ack_drop_latency", to_sw_sig, 0);
    to_hw_sig = 2'd0;
    send_word(16'h00CC);
    repeat (4) @(negedge clk);
    check("hold_acks", ack_cnt, 2);
    check("hold_delivered", exp_q.size(), 0);

    // Reset during the second payload word of a 3-word message
    send_word(16'h9003);
    send_word(16'h0001);
    @(negedge clk);
    to_hw_port = 16'h0002;
    to_hw_sig  = 2'd2;
    wait_sw(2'd2, "mid_ack_timeout");
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {to_sw_sig, msg_valid, msg_type, msg_len, msg_payload, len_err, busy}, 0);
    to_hw_sig = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(pack(4'd4, 4'd1, 16'h0055, 16'h0, 16'h0, 16'h0));
    send_word(16'h4001);
    send_word(16'h0055);
    repeat (4) @(negedge clk);
    check("post_reset_delivered", exp_q.size(), 0);

    // Random-payload messages
    for (int m = 0; m < 4; m++) begin
      logic [3:0] len;
      logic [15:0] w[4];
      len = 4'($urandom_range(0, MAX_WORDS));
      for (int k = 0; k < 4; k++) w[k] = (k < int'(len)) ? 16'($urandom_range(0, 65535)) : 16'h0;
      exp_q.push_back(pack(4'hA, len, w[0], w[1], w[2], w[3]));
      send_word({4'hA, 8'h00, len});
      for (int k = 0; k < int'(len); k++) send_word(w[k]);
      repeat (3) @(negedge clk);
    end
    check("random_delivered", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
